// File: rtl/instruction_cache_param.sv
// Direct-mapped, read-only instruction cache with flush and miss latching.
// Define ICACHE_PERF_CNT_EN to enable the saturating hit/miss counters.
module instruction_cache_param #(
  parameter int ADDR_WIDTH      = 10,
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  localparam int BYTE_BITS = $clog2(WORD_WIDTH / 8),
  localparam int WSEL_BITS = $clog2(WORDS_PER_BLOCK),
  localparam int OFF_BITS  = WSEL_BITS + BYTE_BITS,
  localparam int IDX_BITS  = $clog2(NUM_SETS),
  localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS,
  localparam int BLK_W     = WORD_WIDTH * WORDS_PER_BLOCK
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpuREAD,
  input  logic [ADDR_WIDTH-1:0]      cpuADDRESS,
  input  logic                       cpuFLUSH,
  output logic [WORD_WIDTH-1:0]      cpuREADINSTR,
  output logic                       cpuBUSYWAIT,
  output logic                       imemREAD,
  output logic [ADDR_WIDTH-OFF_BITS-1:0] imemADDRESS,
  input  logic [BLK_W-1:0]           imemREADINSTRBLCK,
  input  logic                       imemBUSYWAIT,
  output logic [31:0]                hitCount,
  output logic [31:0]                missCount
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [NUM_SETS];
  logic [BLK_W-1:0]    data_q [NUM_SETS];
  logic [BLK_W-1:0]    blk_q;
  logic [ADDR_WIDTH-OFF_BITS-1:0] blkaddr_q;
  logic                imem_rd_q;
  logic                flush_pend_q;

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic [WSEL_BITS-1:0] wsel;
  logic [BLK_W-1:0]     line;
  logic [WORD_WIDTH-1:0] word;
  logic [IDX_BITS-1:0]  fill_idx;
  logic [TAG_BITS-1:0]  fill_tag;
  logic                 hit;
  logic                 start_miss;
  logic                 flush_all;
  logic                 unused_addr;

  assign idx  = cpuADDRESS[OFF_BITS +: IDX_BITS];
  assign tag  = cpuADDRESS[ADDR_WIDTH-1 -: TAG_BITS];
  assign wsel = cpuADDRESS[BYTE_BITS +: WSEL_BITS];
  assign line = data_q[idx];
  assign word = line[int'(wsel) * WORD_WIDTH +: WORD_WIDTH];
  assign unused_addr = ^cpuADDRESS;

  assign fill_idx = blkaddr_q[IDX_BITS-1:0];
  assign fill_tag = blkaddr_q[IDX_BITS +: TAG_BITS];

  assign hit = (state_q == IDLE) && cpuREAD &&
               valid_q[idx] && (tag_q[idx] == tag);

  assign imemREAD    = imem_rd_q;
  assign imemADDRESS = blkaddr_q;

  // Next state, CPU-facing outputs and miss/flush decisions.
  always_comb begin
    state_d      = state_q;
    cpuBUSYWAIT  = 1'b1;
    cpuREADINSTR = '0;
    start_miss   = 1'b0;
    flush_all    = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_all = cpuFLUSH;
        if (hit) begin
          cpuBUSYWAIT  = 1'b0;
          cpuREADINSTR = word;
        end else if (!cpuREAD) begin
          cpuBUSYWAIT = 1'b0;
        end else if (!cpuFLUSH) begin
          start_miss = 1'b1;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!imemBUSYWAIT) state_d = UPDATE;
      end
      UPDATE: begin
        flush_all = flush_pend_q || cpuFLUSH;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cpuBUSYWAIT  = 1'b1;
      cpuREADINSTR = '0;
    end
  end

  // Control state: FSM, valid bits, memory request and pending flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      imem_rd_q    <= 1'b0;
      blkaddr_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        blkaddr_q <= {tag, idx};
        imem_rd_q <= 1'b1;
      end
      if (state_q == MEM_READ && !imemBUSYWAIT) begin
        imem_rd_q <= 1'b0;
      end
      if (state_q == UPDATE) begin
        flush_pend_q <= 1'b0;
      end else if (state_q == MEM_READ && cpuFLUSH) begin
        flush_pend_q <= 1'b1;
      end
      if (state_q == UPDATE) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (flush_all) begin
        valid_q <= '0;
      end
    end
  end

  // Block capture and line write; contents are qualified by valid_q.
  always_ff @(posedge clock) begin
    if (state_q == MEM_READ && !imemBUSYWAIT) begin
      blk_q <= imemREADINSTRBLCK;
    end
    if (state_q == UPDATE) begin
      data_q[fill_idx] <= blk_q;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating hit/miss counters, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_miss && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif

endmodule

// File: tb/tb_instruction_cache_param.sv
// Directed bench for instruction_cache_param with a fixed-latency memory.
// Expected hit/miss counts depend on ICACHE_PERF_CNT_EN.
module tb_instruction_cache_param;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpuREAD;
  logic [9:0]   cpuADDRESS;
  logic         cpuFLUSH;
  logic [31:0]  cpuREADINSTR;
  logic         cpuBUSYWAIT;
  logic         imemREAD;
  logic [5:0]   imemADDRESS;
  logic [127:0] imemREADINSTRBLCK;
  logic         imemBUSYWAIT;
  logic [31:0]  hitCount;
  logic [31:0]  missCount;

  int vec = 0;
  int mis = 0;
  int mcnt = 0;

`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  instruction_cache_param dut (
    .clock(clock),
    .reset(reset),
    .cpuREAD(cpuREAD),
    .cpuADDRESS(cpuADDRESS),
    .cpuFLUSH(cpuFLUSH),
    .cpuREADINSTR(cpuREADINSTR),
    .cpuBUSYWAIT(cpuBUSYWAIT),
    .imemREAD(imemREAD),
    .imemADDRESS(imemADDRESS),
    .imemREADINSTRBLCK(imemREADINSTRBLCK),
    .imemBUSYWAIT(imemBUSYWAIT),
    .hitCount(hitCount),
    .missCount(missCount)
  );

  always #5 clock = ~clock;

  // Memory answers on the 5th cycle of a request.
  always @(posedge clock) begin
    if (imemREAD) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  assign imemBUSYWAIT = !(imemREAD && mcnt >= 4);

  function automatic logic [31:0] wd(input int b, input int i);
    return 32'hC0DE_0000 | 32'(b << 4) | 32'(i);
  endfunction

  always_comb begin
    imemREADINSTRBLCK = '0;
    for (int i = 0; i < 4; i++) begin
      imemREADINSTRBLCK[i*32 +: 32] = wd(int'(imemADDRESS), i);
    end
  end

  task automatic chk(input string tg, input logic [63:0] got,
                     input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", tg, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_miss(input string tg, input logic [9:0] a,
                            input logic [5:0] blk);
    int n;
    cpuADDRESS = a;
    cpuREAD    = 1'b1;
    #1;
    chk({tg, "_busy"}, 64'(cpuBUSYWAIT), 64'd1);
    chk({tg, "_instr0"}, 64'(cpuREADINSTR), 64'd0);
    tick;
    n = 1;
    chk({tg, "_imemrd"}, 64'(imemREAD), 64'd1);
    chk({tg, "_imemaddr"}, 64'(imemADDRESS), 64'(blk));
    while (cpuBUSYWAIT && n < 40) begin
      tick;
      n++;
    end
    chk({tg, "_penalty"}, 64'(n), 64'd7);
    chk({tg, "_instr"}, 64'(cpuREADINSTR), 64'(wd(int'(blk), int'(a[3:2]))));
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    cpuREAD    = 1'b0;
    cpuFLUSH   = 1'b0;
    cpuADDRESS = '0;
    #1;
    chk("rst_busy", 64'(cpuBUSYWAIT), 64'd1);
    chk("rst_instr", 64'(cpuREADINSTR), 64'd0);
    chk("rst_imemrd", 64'(imemREAD), 64'd0);
    chk("rst_imemaddr", 64'(imemADDRESS), 64'd0);
    chk("rst_hits", 64'(hitCount), 64'd0);
    chk("rst_miss", 64'(missCount), 64'd0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("idle_busy", 64'(cpuBUSYWAIT), 64'd0);

    // Test 1: cold miss on 0x004
    fetch_miss("t1", 10'h004, 6'h00);

    // Test 2: same-block hits
    tick;
    cpuADDRESS = 10'h008;
    #1;
    chk("t2_busy8", 64'(cpuBUSYWAIT), 64'd0);
    chk("t2_instr8", 64'(cpuREADINSTR), 64'(wd(0, 2)));
    tick;
    cpuADDRESS = 10'h00C;
    #1;
    chk("t2_busyC", 64'(cpuBUSYWAIT), 64'd0);
    chk("t2_instrC", 64'(cpuREADINSTR), 64'(wd(0, 3)));
    tick;
    cpuREAD = 1'b0;
    #1;
    chk("t6_hits", 64'(hitCount), PERF ? 64'd3 : 64'd0);
    chk("t6_miss", 64'(missCount), PERF ? 64'd1 : 64'd0);

    // Test 3: conflict on index 0
    fetch_miss("t3", 10'h084, 6'h08);
    tick;
    cpuADDRESS = 10'h004;
    #1;
    chk("t3_evict", 64'(cpuBUSYWAIT), 64'd1);
    fetch_miss("t3b", 10'h004, 6'h00);

    // Test 4: flush during MEM_READ
    cpuADDRESS = 10'h010;
    #1;
    chk("t4_busy", 64'(cpuBUSYWAIT), 64'd1);
    tick;
    chk("t4_imemrd", 64'(imemREAD), 64'd1);
    cpuFLUSH = 1'b1;
    tick;
    cpuFLUSH = 1'b0;
    repeat (5) tick;
    chk("t4_remiss", 64'(cpuBUSYWAIT), 64'd1);
    chk("t4_instr0", 64'(cpuREADINSTR), 64'd0);
    tick;
    chk("t4_imemrd2", 64'(imemREAD), 64'd1);
    chk("t4_imemaddr2", 64'(imemADDRESS), 64'h01);
    n = 0;
    while (cpuBUSYWAIT && n < 40) begin
      tick;
      n++;
    end
    chk("t4_instr", 64'(cpuREADINSTR), 64'(wd(1, 0)));
    cpuADDRESS = 10'h004;
    #1;
    chk("t4_line0_inv", 64'(cpuBUSYWAIT), 64'd1);
    cpuREAD = 1'b0;

    // Idle flush, then flush beating a miss
    cpuFLUSH = 1'b1;
    tick;
    cpuFLUSH   = 1'b0;
    cpuREAD    = 1'b1;
    cpuADDRESS = 10'h010;
    #1;
    chk("idle_flush", 64'(cpuBUSYWAIT), 64'd1);
    cpuADDRESS = 10'h030;
    cpuFLUSH   = 1'b1;
    tick;
    chk("flush_prio", 64'(imemREAD), 64'd0);
    cpuFLUSH = 1'b0;
    cpuREAD  = 1'b0;
    tick;
    fetch_miss("t5pre", 10'h010, 6'h01);

    // Test 5: reset during MEM_READ
    cpuADDRESS = 10'h020;
    tick;
    tick;
    chk("t5_inread", 64'(imemREAD), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_imemrd", 64'(imemREAD), 64'd0);
    chk("t5_imemaddr", 64'(imemADDRESS), 64'd0);
    chk("t5_busy", 64'(cpuBUSYWAIT), 64'd1);
    chk("t5_instr", 64'(cpuREADINSTR), 64'd0);
    chk("t5_hits", 64'(hitCount), 64'd0);
    chk("t5_miss", 64'(missCount), 64'd0);
    tick;
    reset      = 1'b0;
    cpuADDRESS = 10'h010;
    #1;
    chk("t5_remiss", 64'(cpuBUSYWAIT), 64'd1);
    tick;
    chk("t5_imemrd2", 64'(imemREAD), 64'd1);
    chk("t5_imemaddr2", 64'(imemADDRESS), 64'h01);
    cpuREAD = 1'b0;
    repeat (8) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
